frame_scheduler: RTL

- Sequences the snake game logic against the VGA raster.
- Detects the start of each vertical blanking interval and divides frames down to game ticks.
- Issues one update request per tick to the snake update engine over a req/done handshake.
- Arbitrates the single board-RAM port between the pixel renderer and the update engine.

---
 rtl/snake_pkg.sv | 13 +
 rtl/frame_divider.sv | 42 ++++
 rtl/frame_scheduler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game frame scheduler: FSM encoding and default sizing.
package snake_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } sched_state_e;

   localparam int ADDR_W_DEF          = 10;
   localparam int DIV_W_DEF           = 6;
   localparam int FRAMES_PER_TICK_DEF = 6;

endpackage

// File: rtl/frame_divider.sv
// Detects the first cycle of vertical blanking and divides frames down to game ticks.
module frame_divider
   import snake_pkg::*;
#(
   parameter int DIV_W           = DIV_W_DEF,
   parameter int FRAMES_PER_TICK = FRAMES_PER_TICK_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             v_disp,
   input  logic             pause,
   input  logic [DIV_W-1:0] speed,
   output logic             v_disp_q,
   output logic             tick
);

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] reload;
   logic             frame_edge;

   assign frame_edge = v_disp_q & ~v_disp;
   assign reload     = (speed == '0) ? DIV_W'(FRAMES_PER_TICK) : speed;
   assign tick       = frame_edge & ~pause & (div_cnt == '0);

   // speed only matters at the reload point, so a mid-count change waits for the next tick
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v_disp_q <= 1'b0;
         div_cnt  <= '0;
      end else begin
         v_disp_q <= v_disp;
         if (frame_edge && !pause) begin
            if (div_cnt == '0) begin
               div_cnt <= reload - DIV_W'(1);
            end else begin
               div_cnt <= div_cnt - DIV_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/frame_scheduler.sv
// Issues snake update requests once per game tick and arbitrates the board RAM port.
// Optional frame counter enabled by defining FRAME_COUNTER_EN.
module frame_scheduler
   import snake_pkg::*;
#(
   parameter int FRAMES_PER_TICK = FRAMES_PER_TICK_DEF,
   parameter int DIV_W           = DIV_W_DEF,
   parameter int ADDR_W          = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              v_disp,
   input  logic              h_disp,
   input  logic              pause,
   input  logic [DIV_W-1:0]  speed,
   output logic              upd_req,
   input  logic              upd_done,
   input  logic              upd_mem_req,
   input  logic              upd_mem_we,
   input  logic [ADDR_W-1:0] upd_mem_addr,
   input  logic              ren_mem_req,
   input  logic [ADDR_W-1:0] ren_mem_addr,
   output logic              upd_mem_gnt,
   output logic              ren_mem_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        tick_cnt,
   output logic              overrun,
   output logic [15:0]       frame_cnt
);

   sched_state_e state;
   sched_state_e state_nxt;
   logic         v_disp_q;
   logic         tick;
   logic         v_rise;
   logic         tick_accept;
   logic         overrun_set;
   logic         active;

   frame_divider #(
      .DIV_W           (DIV_W),
      .FRAMES_PER_TICK (FRAMES_PER_TICK)
   ) u_divider (
      .clk      (clk),
      .reset    (reset),
      .v_disp   (v_disp),
      .pause    (pause),
      .speed    (speed),
      .v_disp_q (v_disp_q),
      .tick     (tick)
   );

   assign v_rise = ~v_disp_q & v_disp;

   // A tick that lands while an update is still running is dropped and flagged
   always_comb begin
      state_nxt   = state;
      tick_accept = 1'b0;
      overrun_set = 1'b0;
      case (state)
         IDLE: begin
            if (tick) begin
               state_nxt   = RUN;
               tick_accept = 1'b1;
            end
         end
         RUN: begin
            if (upd_done) begin
               state_nxt = IDLE;
            end
            if (tick || v_rise) begin
               overrun_set = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         tick_cnt <= '0;
         overrun  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (tick_accept) begin
            tick_cnt <= tick_cnt + 8'd1;
         end
         if (overrun_set) begin
            overrun <= 1'b1;
         end
      end
   end

   assign upd_req = (state == RUN);

   // Renderer owns the RAM while pixels are on screen; the engine owns it during blanking
   assign active = v_disp & h_disp;

   always_comb begin
      upd_mem_gnt = 1'b0;
      ren_mem_gnt = 1'b0;
      if (active) begin
         ren_mem_gnt = ren_mem_req;
         upd_mem_gnt = upd_mem_req & ~ren_mem_req;
      end else begin
         upd_mem_gnt = upd_mem_req;
         ren_mem_gnt = ren_mem_req & ~upd_mem_req;
      end
   end

   assign mem_addr = upd_mem_gnt ? upd_mem_addr : ren_mem_addr;
   assign mem_we   = upd_mem_gnt & upd_mem_we;

`ifdef FRAME_COUNTER_EN
   // Counts every blanking start, paused or not
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_cnt <= '0;
      end else if (v_disp_q && !v_disp) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`else
   assign frame_cnt = '0;
`endif

endmodule
